apb_completer_nch: RTL and testbench



---
 rtl/shared_pkg.sv | 23 ++
 rtl/apb_timeout_ctr.sv | 30 +++
 rtl/apb_completer_nch.sv | 211 +++++++++++++++++++++
 tb/tb_apb_completer_nch.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types and constants for the APB multi-channel completer.
// Holds bus width defaults, the FSM state encoding and error-cause codes.
package shared_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CH = 2'd1,
        RESP    = 2'd2
    } state_t;

    typedef logic [2:0] cause_t;

    localparam cause_t CAUSE_NONE  = 3'd0;
    localparam cause_t CAUSE_DEC   = 3'd1;
    localparam cause_t CAUSE_ALIGN = 3'd2;
    localparam cause_t CAUSE_PROT  = 3'd3;
    localparam cause_t CAUSE_TMO   = 3'd4;
    localparam cause_t CAUSE_CH    = 3'd5;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Saturating wait-cycle counter; o_expired is high once the count sits at TIMEOUT-1.
// i_clr has priority over i_en.
module apb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/apb_completer_nch.sv
// APB4 completer that decodes each transfer to one of NUM_CH channels and
// returns a registered PREADY/PSLVERR after the channel (or a timeout) answers.
module apb_completer_nch
    import shared_pkg::*;
#(
    parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int         NUM_CH     = 4,
    parameter int         CH_BITS    = 2,
    parameter logic [2:0] REQ_PROT   = 3'b000,
    parameter logic [2:0] PROT_MASK  = 3'b111,
    parameter int         TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [2:0]                   PPROT,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_CH-1:0]            ch_req,
    output logic                         ch_write,
    output logic [ADDR_WIDTH-1:0]        ch_addr,
    output logic [DATA_WIDTH-1:0]        ch_wdata,
    output logic [DATA_WIDTH/8-1:0]      ch_strb,
    input  logic [NUM_CH-1:0]            ch_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]            ch_err,
    output logic                         proto_err,
    output logic [1:0]                   o_dbg_state,
    output logic [2:0]                   o_dbg_cause
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_KEEP = {ADDR_WIDTH{1'b1}} >> CH_BITS;

    state_t                r_state,   w_state_nxt;
    logic [CH_BITS-1:0]    r_sel,     w_sel_nxt;
    logic [NUM_CH-1:0]     r_req,     w_req_nxt;
    logic                  r_write,   w_write_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,   w_wdata_nxt;
    logic [STRB_W-1:0]     r_strb,    w_strb_nxt;
    logic [DATA_WIDTH-1:0] r_prdata,  w_prdata_nxt;
    logic                  r_pready,  w_pready_nxt;
    logic                  r_pslverr, w_pslverr_nxt;
    logic                  r_proto,   w_proto_nxt;
    cause_t                r_cause,   w_cause_nxt;

    logic [CH_BITS-1:0]    w_sel_in;
    cause_t                w_setup_cause;
    logic [NUM_CH-1:0]     w_onehot_in;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_ctr_clr;
    logic                  w_ctr_en;
    logic                  w_expired;

    assign w_sel_in = PADDR[ADDR_WIDTH-1 -: CH_BITS];

    // Decode has the highest priority when several setup checks fail at once.
    always_comb begin
        w_setup_cause = CAUSE_NONE;
        if ((PPROT & PROT_MASK) != (REQ_PROT & PROT_MASK)) w_setup_cause = CAUSE_PROT;
        if (PADDR[1:0] != 2'b00)                           w_setup_cause = CAUSE_ALIGN;
        if (int'(w_sel_in) >= NUM_CH)                      w_setup_cause = CAUSE_DEC;
    end

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        w_onehot_in = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_sel == CH_BITS'(k)) begin
                w_sel_ready = ch_ready[k];
                w_sel_err   = ch_err[k];
                w_sel_rdata = ch_rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_sel_in == CH_BITS'(k)) w_onehot_in[k] = 1'b1;
        end
    end

    apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .i_clr     (w_ctr_clr),
        .i_en      (w_ctr_en),
        .o_expired (w_expired)
    );

    // Channel handshake: ch_req[sel] rises at the setup edge and stays high
    // until an edge samples ch_ready[sel]=1; ch_err/ch_rdata are taken on that edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_req_nxt     = r_req;
        w_write_nxt   = r_write;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_strb_nxt    = r_strb;
        w_prdata_nxt  = '0;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_proto_nxt   = r_proto;
        w_cause_nxt   = r_cause;
        w_ctr_clr     = 1'b0;
        w_ctr_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_write_nxt = PWRITE;
                    w_addr_nxt  = PADDR & ADDR_KEEP;
                    w_wdata_nxt = PWDATA;
                    w_strb_nxt  = PWRITE ? PSTRB : '0;
                    w_sel_nxt   = w_sel_in;
                    w_cause_nxt = w_setup_cause;
                    w_ctr_clr   = 1'b1;
                    if (w_setup_cause != CAUSE_NONE) begin
                        w_state_nxt   = RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_CH;
                        w_req_nxt   = w_onehot_in;
                    end
                end else if (PSEL && PENABLE) begin
                    w_proto_nxt = 1'b1;
                end
            end
            WAIT_CH: begin
                w_ctr_en = 1'b1;
                if (!PSEL) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = '0;
                    w_proto_nxt = 1'b1;
                end else if (w_sel_ready) begin
                    w_state_nxt   = RESP;
                    w_req_nxt     = '0;
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = w_sel_err;
                    w_prdata_nxt  = (!r_write && !w_sel_err) ? w_sel_rdata : '0;
                    w_cause_nxt   = w_sel_err ? CAUSE_CH : CAUSE_NONE;
                end else if (w_expired) begin
                    w_state_nxt   = RESP;
                    w_req_nxt     = '0;
                    w_pready_nxt  = 1'b1;
                    w_pslverr_nxt = 1'b1;
                    w_cause_nxt   = CAUSE_TMO;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                if (!PSEL) w_proto_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_req     <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_proto   <= 1'b0;
            r_cause   <= CAUSE_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_req     <= w_req_nxt;
            r_write   <= w_write_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_strb    <= w_strb_nxt;
            r_prdata  <= w_prdata_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_proto   <= w_proto_nxt;
            r_cause   <= w_cause_nxt;
        end
    end

    assign PRDATA      = r_prdata;
    assign PREADY      = r_pready;
    assign PSLVERR     = r_pslverr;
    assign ch_req      = r_req;
    assign ch_write    = r_write;
    assign ch_addr     = r_addr;
    assign ch_wdata    = r_wdata;
    assign ch_strb     = r_strb;
    assign proto_err   = r_proto;
    assign o_dbg_state = r_state;
    assign o_dbg_cause = r_cause;

endmodule

// File: tb/tb_apb_completer_nch.sv
// Bench for apb_completer_nch: an APB master plus peripheral responders, checked
// against a transfer-level model (decode rules, ready delay vs timeout arithmetic).
module tb_apb_completer_nch;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int NCH = 3;
    localparam int CHB = 2;
    localparam int TMO = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              PSEL = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PWRITE = 1'b0;
    logic [AW-1:0]     PADDR = '0;
    logic [2:0]        PPROT = '0;
    logic [DW-1:0]     PWDATA = '0;
    logic [SW-1:0]     PSTRB = '0;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [NCH-1:0]    ch_req;
    logic              ch_write;
    logic [AW-1:0]     ch_addr;
    logic [DW-1:0]     ch_wdata;
    logic [SW-1:0]     ch_strb;
    logic [NCH-1:0]    ch_ready = '0;
    logic [NCH*DW-1:0] ch_rdata = '0;
    logic [NCH-1:0]    ch_err = '0;
    logic              proto_err;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_cause;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_proto = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_completer_nch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .CH_BITS    (CHB),
        .REQ_PROT   (3'b000),
        .PROT_MASK  (3'b111),
        .TIMEOUT    (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PPROT       (PPROT),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .ch_req      (ch_req),
        .ch_write    (ch_write),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_strb     (ch_strb),
        .ch_ready    (ch_ready),
        .ch_rdata    (ch_rdata),
        .ch_err      (ch_err),
        .proto_err   (proto_err),
        .o_dbg_state (dbg_state),
        .o_dbg_cause (dbg_cause)
    );

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // One full APB transfer; setup is driven immediately, so calling this right
    // after a previous transfer returns gives a back-to-back sequence.
    task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int d,
                        input logic cerr, input logic [31:0] rdata, input logic noise_all);
        logic [1:0]  sel;
        logic        dec_err;
        logic [2:0]  onehot;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        int          exp_c;
        logic        exp_slv;
        logic [31:0] exp_rd;
        int          got_c;
        int          cnt;
        int          bad;
        sel      = addr[31:30];
        dec_err  = (int'(sel) >= NCH) || (addr[1:0] != 2'b00) || (prot != 3'b000);
        onehot   = dec_err ? 3'b000 : 3'(1 << sel);
        exp_addr = {2'b00, addr[29:0]};
        exp_strb = w ? strb : 4'h0;
        if (dec_err) begin
            exp_c = 0; exp_slv = 1'b1; exp_rd = '0;
        end else if (d < TMO) begin
            exp_c = d + 1; exp_slv = cerr; exp_rd = (!w && !cerr) ? rdata : 32'h0;
        end else begin
            exp_c = TMO; exp_slv = 1'b1; exp_rd = '0;
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = addr;
        PWDATA = wdata; PSTRB = strb; PPROT = prot;
        step();
        PENABLE = 1'b1;
        got_c = -1; cnt = 0; bad = 0;
        for (int c = 0; c <= TMO + 8; c++) begin
            if (ch_req != 3'b000) begin
                cnt++;
                if (ch_req != onehot) bad++;
            end
            if (c == 0 && !dec_err) begin
                n_vec++;
                if ({ch_write, ch_addr, ch_wdata, ch_strb} !== {w, exp_addr, wdata, exp_strb}) begin
                    n_err++;
                    $display("FAIL latch: got w=%b a=%h d=%h s=%h exp w=%b a=%h d=%h s=%h",
                             ch_write, ch_addr, ch_wdata, ch_strb, w, exp_addr, wdata, exp_strb);
                end
            end
            if (PREADY) begin
                got_c = c;
                break;
            end
            PADDR = $urandom; PWDATA = $urandom; PSTRB = 4'($urandom);
            PWRITE = 1'($urandom); PPROT = 3'($urandom);
            for (int k = 0; k < NCH; k++) begin
                ch_rdata[k*DW +: DW] = $urandom;
                ch_err[k]   = 1'($urandom);
                ch_ready[k] = noise_all ? 1'b1 : 1'($urandom);
            end
            if (!dec_err) begin
                ch_ready[sel]           = (c >= d);
                ch_err[sel]             = cerr;
                ch_rdata[sel*DW +: DW]  = rdata;
            end
            step();
        end
        n_vec++;
        if (got_c != exp_c) begin
            n_err++;
            $display("FAIL pready_cycle: got %0d exp %0d (addr %h)", got_c, exp_c, addr);
        end
        n_vec++;
        if (PSLVERR !== exp_slv || PRDATA !== exp_rd) begin
            n_err++;
            $display("FAIL response: got slverr=%b rdata=%h exp slverr=%b rdata=%h",
                     PSLVERR, PRDATA, exp_slv, exp_rd);
        end
        n_vec++;
        if (cnt != (dec_err ? 0 : exp_c) || bad != 0 || ch_req !== 3'b000) begin
            n_err++;
            $display("FAIL ch_req: got %0d cycles bad=%0d final=%b exp %0d cycles final=000",
                     cnt, bad, ch_req, dec_err ? 0 : exp_c);
        end
        step();
        PSEL = 1'b0; PENABLE = 1'b0; ch_ready = '0; ch_err = '0;
        n_vec++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || proto_err !== exp_proto) begin
            n_err++;
            $display("FAIL after_resp: got pready=%b slverr=%b proto=%b exp 0 0 %b",
                     PREADY, PSLVERR, proto_err, exp_proto);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        step();
        step();
        n_vec++;
        if ({PRDATA, PREADY, PSLVERR, ch_req, ch_write, ch_addr, ch_wdata, ch_strb, proto_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdata=%h rdy=%b err=%b req=%b addr=%h proto=%b exp all 0",
                     PRDATA, PREADY, PSLVERR, ch_req, ch_addr, proto_err);
        end
        PRESETn = 1'b1;
        exp_proto = 1'b0;
        step();
    endtask

    task automatic test_write_ch1();
        xfer(1'b1, 32'h4000_0010, 32'hCAFE_0123, 4'b0011, 3'b000, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_read_ch2_delay();
        step();
        xfer(1'b0, 32'h8000_0020, 32'h0, 4'hF, 3'b000, 5, 1'b0, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_decode_errors();
        step();
        xfer(1'b0, 32'hC000_0000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h1111_1111, 1'b0);
        xfer(1'b0, 32'h0000_0002, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h2222_2222, 1'b0);
        xfer(1'b1, 32'h4000_0000, 32'h5, 4'hF, 3'b001, 0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        step();
        xfer(1'b0, 32'h4000_0100, 32'h0, 4'h0, 3'b000, 1000, 1'b0, 32'h0, 1'b0);
        ch_ready = 3'b111;
        ch_rdata = {3{32'hBAD0_BAD0}};
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (ch_req !== 3'b000 || PREADY !== 1'b0 || PRDATA !== '0) begin
                n_err++;
                $display("FAIL late_ready: got req=%b pready=%b rdata=%h exp 000 0 0",
                         ch_req, PREADY, PRDATA);
            end
        end
        ch_ready = '0;
    endtask

    task automatic test_ch_err_and_ignore();
        step();
        xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b000, 2, 1'b1, 32'h7777_7777, 1'b0);
        step();
        xfer(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b000, 4, 1'b0, 32'h0BAD_F00D, 1'b1);
    endtask

    task automatic test_random();
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [2:0]  prot;
        int          d;
        for (int i = 0; i < 24; i++) begin
            sel  = 2'($urandom_range(0, 3));
            addr = {sel, 30'($urandom)} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            prot = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            d    = ($urandom_range(0, 5) == 0) ? 40 : int'($urandom_range(0, 6));
            xfer(1'($urandom), addr, $urandom, 4'($urandom), prot, d,
                 ($urandom_range(0, 3) == 0), $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_back_to_back();
        step();
        xfer(1'b1, 32'h0000_0008, 32'hA5A5_0001, 4'hF, 3'b000, 0, 1'b0, 32'h0, 1'b0);
        xfer(1'b0, 32'h4000_000C, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'h1357_9BDF, 1'b0);
        xfer(1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h2468_ACE0, 1'b0);
    endtask

    task automatic test_psel_drop();
        step();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h4000_0040; PPROT = 3'b000;
        step();
        PENABLE = 1'b1;
        step();
        step();
        n_vec++;
        if (ch_req !== 3'b010) begin
            n_err++;
            $display("FAIL drop_pre_req: got %b exp 010", ch_req);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        exp_proto = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (ch_req !== 3'b000 || proto_err !== 1'b1 || PREADY !== 1'b0) begin
                n_err++;
                $display("FAIL psel_drop: got req=%b proto=%b pready=%b exp 000 1 0",
                         ch_req, proto_err, PREADY);
            end
        end
    endtask

    task automatic test_no_setup();
        n_vec++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL proto_clear: got %b exp 0", proto_err);
        end
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h4000_0000; PPROT = 3'b000;
        exp_proto = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (proto_err !== 1'b1 || PREADY !== 1'b0 || ch_req !== 3'b000) begin
                n_err++;
                $display("FAIL no_setup: got proto=%b pready=%b req=%b exp 1 0 000",
                         proto_err, PREADY, ch_req);
            end
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h8000_0010;
        PWDATA = 32'h1234_5678; PSTRB = 4'hF; PPROT = 3'b000;
        step();
        PENABLE = 1'b1;
        step();
        n_vec++;
        if (ch_req !== 3'b100) begin
            n_err++;
            $display("FAIL rst_pre_req: got %b exp 100", ch_req);
        end
        #2;
        PRESETn = 1'b0;
        #1;
        n_vec++;
        if ({PRDATA, PREADY, PSLVERR, ch_req, ch_write, ch_addr, ch_wdata, ch_strb, proto_err} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got req=%b w=%b addr=%h wdata=%h strb=%h proto=%b exp all 0",
                     ch_req, ch_write, ch_addr, ch_wdata, ch_strb, proto_err);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        exp_proto = 1'b0;
        step();
        PRESETn = 1'b1;
        step();
        xfer(1'b0, 32'h8000_0010, 32'h0, 4'h0, 3'b000, 1, 1'b0, 32'h0F0F_F0F0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_ch1();
        test_read_ch2_delay();
        test_decode_errors();
        test_timeout();
        test_ch_err_and_ignore();
        test_random();
        test_back_to_back();
        test_psel_drop();
        test_reset();
        test_no_setup();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
